// File: rtl/systolic_ctrl_pkg.sv
// Shared definitions for the systolic array sequencer: FSM state encodings and buffer selects.
package systolic_ctrl_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLEAR = 3'd1;
    localparam logic [2:0] ST_FEED  = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/systolic_ctrl_skew_sel.sv
// Combinational diagonal-skew selector: picks one element per lane of a flattened KxK matrix for feed step t.
module skew_sel
    import systolic_ctrl_pkg::*;
#(
    parameter int K         = 3,
    parameter int DW        = 8,
    parameter int T_W       = 3,
    parameter bit TRANSPOSE = 1'b0
) (
    input  logic [K*K*DW-1:0] mat,
    input  logic [T_W-1:0]    t,
    output logic [K*DW-1:0]   lanes
);

    // Lane i carries element (i, t-i) row-wise, or (t-i, i) when transposed for column feeds.
    always_comb begin
        int d;
        int idx;
        // NOTE: every output and temporary gets a default before the loop so no latch is inferred.
        lanes = '0;
        d     = 0;
        idx   = 0;
        for (int i = 0; i < K; i++) begin
            d = int'(t) - i;
            if (d >= 0 && d < K) begin
                idx = TRANSPOSE ? (d * K + i) : (i * K + d);
                lanes[i*DW +: DW] = mat[idx*DW +: DW];
            end
        end
    end

endmodule

// File: rtl/systolic_ctrl.sv
// Sequencer for a KxK pe array: buffers A/B, streams them with diagonal skew, clears and drains.
// Optional busy-cycle counter port cyc_cnt is built when SYS_CTRL_CYC_CNT_EN is defined.
module systolic_ctrl
    import systolic_ctrl_pkg::*;
#(
    parameter int K      = 3,
    parameter int DW     = 8,
    parameter int PE_LAT = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_en,
    input  logic            wr_sel,
    input  logic [5:0]      wr_addr,
    input  logic [DW-1:0]   wr_data,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            wr_err,
    output logic            pe_clr,
    output logic            feed_vld,
    output logic [K*DW-1:0] a_edge,
    output logic [K*DW-1:0] b_edge
`ifdef SYS_CTRL_CYC_CNT_EN
    ,
    output logic [15:0]     cyc_cnt
`endif
);

    localparam int N       = K * K;
    localparam int AW      = (N > 1) ? $clog2(N) : 1;
    localparam int T_W     = $clog2(2 * K - 1);
    localparam int T_LAST  = 2 * K - 2;
    localparam int DR_W    = $clog2(K * PE_LAT + 1);
    localparam int DR_LAST = (K - 1) * PE_LAT;

    logic [2:0]      state, state_next;
    logic [T_W-1:0]  t_cnt, t_next;
    logic [DR_W-1:0] dr_cnt, dr_next;

    logic [DW-1:0]   a_mem [N];
    logic [DW-1:0]   b_mem [N];
    logic [N*DW-1:0] a_flat, b_flat;
    logic [K*DW-1:0] a_skew, b_skew;

    logic wr_bad, wr_ok;

    assign wr_bad = wr_en && (state != ST_IDLE || int'(wr_addr) >= N);
    assign wr_ok  = wr_en && !wr_bad;

    always_comb begin
        a_flat = '0;
        b_flat = '0;
        for (int n = 0; n < N; n++) begin
            a_flat[n*DW +: DW] = a_mem[n];
            b_flat[n*DW +: DW] = b_mem[n];
        end
    end

    always_comb begin
        state_next = state;
        t_next     = t_cnt;
        dr_next    = dr_cnt;
        case (state)
            ST_IDLE:  if (start) state_next = ST_CLEAR;
            ST_CLEAR: begin
                state_next = ST_FEED;
                t_next     = '0;
            end
            ST_FEED: begin
                if (t_cnt == T_W'(T_LAST)) begin
                    state_next = ST_DRAIN;
                    dr_next    = '0;
                end else begin
                    t_next = t_cnt + T_W'(1);
                end
            end
            ST_DRAIN: begin
                if (dr_cnt == DR_W'(DR_LAST)) state_next = ST_DONE;
                else                          dr_next    = dr_cnt + DR_W'(1);
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // The skew is looked up with the next step so the edge registers present step t during that cycle.
    skew_sel #(.K(K), .DW(DW), .T_W(T_W), .TRANSPOSE(1'b0)) u_skew_a (
        .mat   (a_flat),
        .t     (t_next),
        .lanes (a_skew)
    );

    skew_sel #(.K(K), .DW(DW), .T_W(T_W), .TRANSPOSE(1'b1)) u_skew_b (
        .mat   (b_flat),
        .t     (t_next),
        .lanes (b_skew)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            t_cnt    <= '0;
            dr_cnt   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            wr_err   <= 1'b0;
            pe_clr   <= 1'b0;
            feed_vld <= 1'b0;
            a_edge   <= '0;
            b_edge   <= '0;
        end else begin
            state    <= state_next;
            t_cnt    <= t_next;
            dr_cnt   <= dr_next;
            busy     <= (state_next != ST_IDLE);
            done     <= (state_next == ST_DONE);
            wr_err   <= wr_bad;
            pe_clr   <= (state_next == ST_CLEAR);
            feed_vld <= (state_next == ST_FEED);
            a_edge   <= (state_next == ST_FEED) ? a_skew : '0;
            b_edge   <= (state_next == ST_FEED) ? b_skew : '0;
        end
    end

    // NOTE: the operand buffers are flop arrays with a reset, so a run straight after reset streams zeros.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int n = 0; n < N; n++) begin
                a_mem[n] <= '0;
                b_mem[n] <= '0;
            end
        end else if (wr_ok) begin
            if (wr_sel == SEL_A) a_mem[wr_addr[AW-1:0]] <= wr_data;
            if (wr_sel == SEL_B) b_mem[wr_addr[AW-1:0]] <= wr_data;
        end
    end

`ifdef SYS_CTRL_CYC_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc_cnt <= '0;
        end else if (state == ST_IDLE && start) begin
            cyc_cnt <= '0;
        end else if (state != ST_IDLE && cyc_cnt != 16'hFFFF) begin
            cyc_cnt <= cyc_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// Scoreboard bench for systolic_ctrl with K=2: stimulus queues expected events, a negedge monitor checks them.
module tb_systolic_ctrl;

    localparam int K  = 2;
    localparam int DW = 8;

    logic            clk;
    logic            reset;
    logic            wr_en;
    logic            wr_sel;
    logic [5:0]      wr_addr;
    logic [DW-1:0]   wr_data;
    logic            start;
    logic            busy;
    logic            done;
    logic            wr_err;
    logic            pe_clr;
    logic            feed_vld;
    logic [K*DW-1:0] a_edge;
    logic [K*DW-1:0] b_edge;
`ifdef SYS_CTRL_CYC_CNT_EN
    logic [15:0]     cyc_cnt;
`endif

    systolic_ctrl #(.K(K), .DW(DW), .PE_LAT(1)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_sel   (wr_sel),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .wr_err   (wr_err),
        .pe_clr   (pe_clr),
        .feed_vld (feed_vld),
        .a_edge   (a_edge),
        .b_edge   (b_edge)
`ifdef SYS_CTRL_CYC_CNT_EN
        ,
        .cyc_cnt  (cyc_cnt)
`endif
    );

    typedef struct {
        int          cyc;
        logic [15:0] a;
        logic [15:0] b;
    } feed_t;

    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    int    q_clr[$];
    int    q_done[$];
    int    q_err[$];
    feed_t q_feed[$];

    logic [15:0] exp_a[3];
    logic [15:0] exp_b[3];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        total++;
        bad++;
        $display("FAIL %s: got an unexpected event expected none (cycle %0d)", name, cyc);
    endtask

    // Monitor: pops the matching queue whenever the DUT presents an event.
    always @(negedge clk) begin
        feed_t e;
        if (pe_clr) begin
            if (q_clr.size() == 0) unexpected("pe_clr");
            else check("pe_clr_cycle", cyc, q_clr.pop_front());
        end
        if (feed_vld) begin
            if (q_feed.size() == 0) unexpected("feed_vld");
            else begin
                e = q_feed.pop_front();
                check("feed_cycle", cyc, e.cyc);
                check("a_edge", a_edge, e.a);
                check("b_edge", b_edge, e.b);
            end
        end else begin
            check("edges_idle", {a_edge, b_edge}, 32'd0);
        end
        if (done) begin
            if (q_done.size() == 0) unexpected("done");
            else check("done_cycle", cyc, q_done.pop_front());
        end
        if (wr_err) begin
            if (q_err.size() == 0) unexpected("wr_err");
            else check("wr_err_cycle", cyc, q_err.pop_front());
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_wr_err"}, wr_err, 1'b0);
        check({tag, "_pe_clr"}, pe_clr, 1'b0);
        check({tag, "_feed_vld"}, feed_vld, 1'b0);
        check({tag, "_a_edge"}, a_edge, 16'd0);
        check({tag, "_b_edge"}, b_edge, 16'd0);
    endtask

    task automatic wr(input logic sel, input int addr, input int data, input bit expect_err);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = 6'(addr);
        wr_data = 8'(data);
        if (expect_err) q_err.push_back(cyc + 1);
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic load_k2();
        for (int n = 0; n < 4; n++) begin
            wr(1'b0, n, n + 1, 1'b0);
            wr(1'b1, n, n + 5, 1'b0);
        end
    endtask

    task automatic set_exp(input bit zero);
        if (zero) begin
            exp_a = '{16'h0000, 16'h0000, 16'h0000};
            exp_b = '{16'h0000, 16'h0000, 16'h0000};
        end else begin
            exp_a = '{16'h0001, 16'h0302, 16'h0400};
            exp_b = '{16'h0005, 16'h0607, 16'h0800};
        end
    endtask

    task automatic push_run(input int c0);
        feed_t fe;
        q_clr.push_back(c0 + 1);
        for (int t = 0; t < 3; t++) begin
            fe.cyc = c0 + 2 + t;
            fe.a   = exp_a[t];
            fe.b   = exp_b[t];
            q_feed.push_back(fe);
        end
        q_done.push_back(c0 + 7);
    endtask

    // One full run; returns in the IDLE cycle right after done, ready for a back-to-back start.
    task automatic run(input bit hold_start, input bit wr_busy);
        int c0;
        c0    = cyc;
        start = 1'b1;
        push_run(c0);
        @(posedge clk); #1;
        if (!hold_start) start = 1'b0;
        check("busy_after_start", busy, 1'b1);
        if (wr_busy) begin
            wr_en   = 1'b1;
            wr_sel  = 1'b0;
            wr_addr = 6'd0;
            wr_data = 8'd9;
            q_err.push_back(cyc + 1);
        end
        @(posedge clk); #1;
        wr_en = 1'b0;
        while (cyc < c0 + 8) begin
            if (cyc >= c0 + 5) start = 1'b0;
            @(posedge clk); #1;
        end
        start = 1'b0;
        check("busy_back_idle", busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_sel  = 1'b0;
        wr_addr = 6'd0;
        wr_data = 8'd0;
        start   = 1'b0;

        for (int i = 0; i < 4; i++) begin
            wr_en   = i[0];
            start   = ~i[0];
            wr_addr = 6'(i);
            wr_data = 8'(i + 1);
            @(negedge clk);
            check_zero("reset_held");
        end
        @(posedge clk); #1;
        reset = 1'b0;
        wr_en = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;

        set_exp(1'b1);
        run(1'b0, 1'b0);

        load_k2();
        set_exp(1'b0);
        run(1'b0, 1'b0);
`ifdef SYS_CTRL_CYC_CNT_EN
        check("cyc_cnt", cyc_cnt, 16'd7);
`endif

        run(1'b0, 1'b1);
        run(1'b0, 1'b0);

        wr(1'b0, 4, 8'hAA, 1'b1);
        @(posedge clk); #1;
        run(1'b0, 1'b0);

        run(1'b1, 1'b0);
        run(1'b0, 1'b0);

        c0    = cyc;
        start = 1'b1;
        push_run(c0);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check_zero("mid_reset");
        q_clr.delete();
        q_feed.delete();
        q_done.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        set_exp(1'b1);
        run(1'b0, 1'b0);
        load_k2();
        set_exp(1'b0);
        run(1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("q_clr_empty", q_clr.size(), 0);
        check("q_feed_empty", q_feed.size(), 0);
        check("q_done_empty", q_done.size(), 0);
        check("q_err_empty", q_err.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
